// File: rtl/adc_avg_bcd.sv
// adc_avg_bcd: detects completed conversions from the serial ADC capture
// stage, averages a 2^AVG_LOG2 window of samples, scales the average to
// millivolts and converts it to four packed BCD digits for the display.
// Optional feature macro: ADC_AVG_BCD_PEAK_HOLD_EN adds the `peak` output,
// the running maximum of raw samples since reset.
`timescale 1ns/1ps
module adc_avg_bcd #(
  parameter int AVG_LOG2 = 2,
  parameter int VREF_MV  = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic [7:0]  data,
  output logic [7:0]  avg,
  output logic [15:0] bcd,
  output logic        valid,
  output logic        busy
`ifdef ADC_AVG_BCD_PEAK_HOLD_EN
  ,
  output logic [7:0]  peak
`endif
);

  localparam int AW = 8 + AVG_LOG2;
  // cnt is zero-width when AVG_LOG2 is 0; keep one bit and ignore it then.
  localparam int CW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;

  typedef enum logic [1:0] {IDLE, SCALE, CONV, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic           cs_q;
  logic           strobe;
  logic [AW-1:0]  acc;
  logic [AW-1:0]  sum;
  logic [CW-1:0]  cnt;
  logic           last;
  logic           pend;
  logic [7:0]     avg_next;
  logic [7:0]     avg_work;
  logic [21:0]    prod;
  logic [12:0]    mv;
  logic [28:0]    dd;
  logic [28:0]    dd_step;
  logic [15:0]    adj;
  logic [3:0]     iter;
  logic           load;
  logic           scale_en;
  logic           conv_en;
  logic           finish;
  logic           unused_bits;

  // Upstream raises cs_n and updates data on the same edge, so data is
  // already valid in the strobe cycle.
  assign strobe = cs_n & ~cs_q;
  // The full window sum of 2^AVG_LOG2 bytes always fits in AW bits.
  assign sum    = acc + AW'(data);
  assign last   = (AVG_LOG2 == 0) ? 1'b1 : (cnt == {CW{1'b1}});

  // Scaled value in mV; the low 8 bits are the discarded fraction.
  assign prod        = 22'(avg_work) * 22'(VREF_MV);
  assign mv          = prod[20:8];
  assign unused_bits = ^{prod[21], prod[7:0], adj[15]};

  // One double-dabble iteration: bias every BCD nibble >= 5, then shift.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (dd[13+gi*4 +: 4] >= 4'd5) ?
                              (dd[13+gi*4 +: 4] + 4'd3) : dd[13+gi*4 +: 4];
    end
  endgenerate
  assign dd_step = {adj[14:0], dd[12:0], 1'b0};

  // Delay cs_n by one cycle for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cs_q <= 1'b1;
    else        cs_q <= cs_n;
  end

  // Window accumulation runs independently of the FSM; a newer window
  // average simply overwrites one the FSM has not picked up yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      avg_next <= '0;
      pend     <= 1'b0;
    end else begin
      if (strobe && last) begin
        acc      <= '0;
        cnt      <= '0;
        avg_next <= sum[AVG_LOG2 +: 8];
      end else if (strobe) begin
        acc <= sum;
        cnt <= cnt + CW'(1);
      end
      // A completing window must win over the FSM consuming the old one.
      if (strobe && last) pend <= 1'b1;
      else if (load)      pend <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state and datapath controls.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    scale_en   = 1'b0;
    conv_en    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (pend) begin
        load       = 1'b1;
        state_next = SCALE;
      end
      SCALE: begin
        scale_en   = 1'b1;
        state_next = CONV;
      end
      CONV: begin
        conv_en = 1'b1;
        if (iter == 4'd12) begin
          finish     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Conversion datapath: latch the average, scale it, then shift 13 times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg_work <= '0;
      dd       <= '0;
      iter     <= '0;
    end else begin
      if (load) avg_work <= avg_next;
      if (scale_en) begin
        dd   <= {16'd0, mv};
        iter <= '0;
      end else if (conv_en) begin
        dd   <= dd_step;
        iter <= iter + 4'd1;
      end
    end
  end

  // Results are captured with the final shift so that avg/bcd change on the
  // same edge that raises valid, and valid is high during DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avg   <= '0;
      bcd   <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      valid <= finish;
      busy  <= (state_next != IDLE);
      if (finish) begin
        avg <= avg_work;
        bcd <= dd_step[28:13];
      end
    end
  end

`ifdef ADC_AVG_BCD_PEAK_HOLD_EN
  // Running maximum of raw samples; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     peak <= '0;
    else if (strobe && data > peak) peak <= data;
  end
`endif

endmodule
